// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the scan chain bank: the 2-bit scan mode encoding.
// All four encodings are legal, so no illegal-mode handling exists anywhere.
// -----------------------------------------------------------------------------
package scan_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_NORMAL  = 2'b00,  // functional path: data_out follows data_in
    MODE_CAPTURE = 2'b01,  // parallel load of the capture register
    MODE_SHIFT   = 2'b10,  // serial shift of every chain
    MODE_UPDATE  = 2'b11   // transfer capture register to data_out
  } mode_t;

endpackage

// File: rtl/scan_chain_segment.sv
// -----------------------------------------------------------------------------
// scan_chain_segment
// One LEN-bit scan chain. It captures parallel data, shifts serially toward
// its MSB, or holds.
// Ports:
//   clk, rst_n  - clock (rising edge), asynchronous active-low reset
//   i_mode      - scan mode (scan_pkg::mode_t)
//   i_data      - parallel capture data for this chain
//   i_scan_in   - serial input, enters at the LSB
//   o_chain     - current chain contents (MSB is the serial output)
// -----------------------------------------------------------------------------
module scan_chain_segment
  import scan_pkg::*;
#(
  parameter int LEN = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  mode_t          i_mode,
  input  logic [LEN-1:0] i_data,
  input  logic           i_scan_in,
  output logic [LEN-1:0] o_chain
);

  logic [LEN-1:0] r_chain;
  logic [LEN-1:0] w_shifted;

  // A one-bit chain has no lower bits to carry, so it just loads the serial bit.
  generate
    if (LEN == 1) begin : g_single
      assign w_shifted = i_scan_in;
    end else begin : g_multi
      assign w_shifted = {r_chain[LEN-2:0], i_scan_in};
    end
  endgenerate

  // NOTE: non-blocking (<=) assignments in clocked blocks. Every flop then
  // samples pre-edge values, so chains and counters update together.
  // NOTE: the chain is a register bank, not a memory. It must reset, because
  // scan_out (and parity) are required to read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      case (i_mode)
        MODE_CAPTURE: r_chain <= i_data;
        MODE_SHIFT:   r_chain <= w_shifted;
        default:      ;  // NORMAL and UPDATE hold the chain
      endcase
    end
  end

  assign o_chain = r_chain;

endmodule

// File: rtl/scan_chain_bank.sv
// -----------------------------------------------------------------------------
// scan_chain_bank
// Multi-chain DFT scan register. A WIDTH-bit capture register is split into
// CHAINS chains of CHAIN_LEN bits that shift in parallel. The functional
// output changes only in NORMAL (tracks data_in) or UPDATE (loads cap_reg).
// Chain c occupies cap_reg[c*CHAIN_LEN +: CHAIN_LEN]; its MSB drives scan_out[c].
// WIDTH must be a multiple of CHAINS, and CHAINS must be >= 1.
//
// Ports:
//   clk, rst_n  - clock (rising edge), asynchronous active-low reset
//   mode        - 00 NORMAL, 01 CAPTURE, 10 SHIFT, 11 UPDATE
//   data_in     - functional / capture data
//   data_out    - registered functional output (update register)
//   scan_in     - serial input, one bit per chain
//   scan_out    - serial output, one bit per chain (combinational from cap_reg)
//   shift_cnt   - shifts completed in the current SHIFT pass, saturates at CHAIN_LEN
//   shift_done  - one-cycle pulse after the CHAIN_LEN-th consecutive shift
//   cap_parity  - XOR of cap_reg; present only when SCAN_PARITY_EN is defined
//
// Configuration macro: SCAN_PARITY_EN (adds the cap_parity output).
// -----------------------------------------------------------------------------
module scan_chain_bank
  import scan_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int CHAINS    = 2,
  localparam int CHAIN_LEN = WIDTH / CHAINS,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  data_out,
  input  logic [CHAINS-1:0] scan_in,
  output logic [CHAINS-1:0] scan_out,
  output logic [CNT_W-1:0]  shift_cnt,
`ifdef SCAN_PARITY_EN
  output logic              shift_done,
  output logic              cap_parity
`else
  output logic              shift_done
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  mode_t            w_mode;
  logic [WIDTH-1:0] w_cap_reg;
  logic [WIDTH-1:0] r_data_out;
  logic [CNT_W-1:0] r_shift_cnt;
  logic             r_shift_done;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_done_next;

  assign w_mode = mode_t'(mode);

  // One segment per chain; together they form cap_reg.
  generate
    for (genvar c = 0; c < CHAINS; c++) begin : g_chain
      scan_chain_segment #(
        .LEN (CHAIN_LEN)
      ) u_segment (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_mode    (w_mode),
        .i_data    (data_in[c*CHAIN_LEN +: CHAIN_LEN]),
        .i_scan_in (scan_in[c]),
        .o_chain   (w_cap_reg[c*CHAIN_LEN +: CHAIN_LEN])
      );
      assign scan_out[c] = w_cap_reg[c*CHAIN_LEN + CHAIN_LEN - 1];
    end
  endgenerate

  // Update register: loads in NORMAL and UPDATE, holds in CAPTURE and SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= '0;
    end else begin
      case (w_mode)
        MODE_NORMAL: r_data_out <= data_in;
        MODE_UPDATE: r_data_out <= w_cap_reg;
        default:     ;
      endcase
    end
  end

  // Pass counter. Any non-SHIFT cycle restarts the pass. The done pulse fires
  // only on the CHAIN_LEN-1 -> CHAIN_LEN step, so a saturated counter stays quiet.
  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_cnt_next  = '0;
    w_done_next = 1'b0;
    if (w_mode == MODE_SHIFT) begin
      w_cnt_next  = (r_shift_cnt == CNT_MAX) ? r_shift_cnt : r_shift_cnt + CNT_W'(1);
      w_done_next = (r_shift_cnt == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift_cnt  <= '0;
      r_shift_done <= 1'b0;
    end else begin
      r_shift_cnt  <= w_cnt_next;
      r_shift_done <= w_done_next;
    end
  end

  assign data_out   = r_data_out;
  assign shift_cnt  = r_shift_cnt;
  assign shift_done = r_shift_done;

`ifdef SCAN_PARITY_EN
  // Integrity check on the captured image; it reads zero in reset because cap_reg does.
  assign cap_parity = ^w_cap_reg;
`endif

endmodule

// File: doc/scan_chain_bank.md
Name: scan_chain_bank

Overview:
Parametrised multi-chain scan register for DFT insertion around datapath registers.
- Splits a WIDTH-bit capture register into CHAINS independent scan chains that shift in parallel.
- Separates capture, shift and update into distinct modes, so the functional output only changes on an explicit update.
- Tracks shift progress with a per-pass counter and a completion pulse for the test controller.

Parameters:
- WIDTH, 16, total data/capture bits; must be a multiple of CHAINS.
- CHAINS, 2, number of parallel scan chains; must be ≥1.
- CHAIN_LEN, WIDTH/CHAINS, bits per chain; derived, not overridden.
- CNT_W, $clog2(CHAIN_LEN+1), width of the shift counter; derived.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- mode  input  2  00 NORMAL, 01 CAPTURE, 10 SHIFT, 11 UPDATE.
- data_in  input  WIDTH  functional/capture data.
- data_out  output  WIDTH  registered functional output (update register).
- scan_in  input  CHAINS  serial input, one bit per chain.
- scan_out  output  CHAINS  serial output, one bit per chain.
- shift_cnt  output  CNT_W  shifts completed in the current SHIFT pass.
- shift_done  output  1  one-cycle pulse on completion of the CHAIN_LEN-th consecutive shift.

Behaviour:
- Reset (async, asserted): cap_reg=0, data_out=0, shift_cnt=0, shift_done=0. Consequently scan_out=0.
- Reset asserted mid-operation clears all state immediately; the pass is lost.
- Chain c occupies cap_reg[c*CHAIN_LEN +: CHAIN_LEN].
- scan_out[c] = MSB of chain c, combinational from cap_reg (no extra latency).
- NORMAL (00): data_out <= data_in (1-cycle latency); cap_reg holds.
- CAPTURE (01): cap_reg <= data_in; data_out holds.
- SHIFT (10):
  - Each chain does chain <= {chain[CHAIN_LEN-2:0], scan_in[c]}.
  - For CHAIN_LEN=1, chain <= scan_in[c].
  - First bit shifted in ends at the MSB after CHAIN_LEN shifts. data_out holds.
- UPDATE (11): data_out <= cap_reg; cap_reg holds.
- Counter:
  - In SHIFT, shift_cnt increments each cycle and saturates at CHAIN_LEN.
  - Any non-SHIFT cycle clears shift_cnt to 0 on that edge.
- shift_done:
  - Registered. Asserted for exactly one cycle, after the edge on which shift_cnt goes CHAIN_LEN-1 -> CHAIN_LEN.
  - Not re-asserted while saturated; extra shifts keep shifting data.
- Interrupted pass: leaving SHIFT early keeps the partially shifted cap_reg contents; the counter restarts from 0 on the next SHIFT.
- No illegal mode values; all four encodings are defined.

Optional Feature:
- Macro SCAN_PARITY_EN.
- Defined: adds output cap_parity (1 bit) = XOR reduction of cap_reg, combinational. Reset value 0 follows from cap_reg=0. Used for an on-chip chain integrity check after capture.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package scan_pkg:
  - 2-bit mode constants MODE_NORMAL/MODE_CAPTURE/MODE_SHIFT/MODE_UPDATE.
  - A mode typedef.
- One sub-module, scan_chain_segment (one CHAIN_LEN-bit chain: capture/shift/hold), instantiated CHAINS times via generate.
- Top-level holds data_out, the counter and shift_done.

Test Plan:
All scenarios use WIDTH=8, CHAINS=2, CHAIN_LEN=4.
1. Reset: assert rst_n=0 mid-clock -> data_out=0x00, scan_out=2'b00, shift_cnt=0, shift_done=0 immediately, with no clock edge needed.
2. NORMAL with data_in=0xA5 -> data_out=0xA5 after one edge; then CAPTURE 0x3C -> data_out still 0xA5.
3. CAPTURE 0x3C, then 4×SHIFT with scan_in=00:
   - scan_out[0] sequence 1,1,0,0; scan_out[1] sequence 0,0,1,1.
   - shift_cnt 1,2,3,4; shift_done high one cycle after the 4th edge.
   - cap_reg=0x00 afterwards.
4. 4×SHIFT with scan_in[0]=1,0,1,1 and scan_in[1]=0,1,1,0, then UPDATE -> data_out=0x6B.
5. Interrupted pass: 2×SHIFT, 1×NORMAL, 4×SHIFT -> shift_cnt returns to 0 on the NORMAL cycle; shift_done pulses once, only after the final 4th shift. 5th consecutive SHIFT -> no second pulse, shift_cnt stays 4.
6. With SCAN_PARITY_EN: CAPTURE 0x07 -> cap_parity=1; CAPTURE 0x0F -> cap_parity=0; assert rst_n mid-SHIFT -> cap_parity=0.
